// File: rtl/instr_fetch_pkg.sv
// Shared constants and fetch FSM encoding for the instruction fetch unit.
// Imported by instr_fetch and its optional ack watchdog.
package instr_fetch_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADJ_SEQ   = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    STEP,
    SETTLE
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_watchdog.sv
// Ack watchdog for instr_fetch: counts edges spent waiting in REQ and
// raises a sticky fault when the memory never answers.
module instr_fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic update_clk,
  input  logic reset_clk,
  input  logic active,
  input  logic ack,
  output logic expire,
  output logic fault
);

  localparam int CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt;

  // expire marks the edge that would be the last one allowed without ack
  assign expire = active && !ack &&
                  (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge update_clk or posedge reset_clk) begin
    if (reset_clk) begin
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      if (!active) cnt <= '0;
      else         cnt <= cnt + 1'b1;
      if (expire) fault <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads ip, fetches over req/ack, hands word to decoder,
// then drives adj and a one-cycle ip_step. Optional watchdog: FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int WORD_SIZE      = instr_fetch_pkg::WORD_SIZE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 reset_clk,
  input  logic                 update_clk,
  input  logic [WORD_SIZE-1:0] ip,
  input  logic                 halt,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] branch_offset,
  output logic [WORD_SIZE-1:0] adj,
  output logic                 ip_step,
  output logic                 fault
);

  import instr_fetch_pkg::*;

  fetch_state_t state_q, state_d;

  logic [WORD_SIZE-1:0] addr_d, instr_d, adj_d;
  logic                 req_d, valid_d, step_d;
  logic                 expire;

`ifdef FETCH_TIMEOUT_EN
  instr_fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .update_clk(update_clk),
    .reset_clk (reset_clk),
    .active    (state_q == REQ),
    .ack       (mem_ack),
    .expire    (expire),
    .fault     (fault)
  );
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign expire = 1'b0;
  assign fault  = 1'b0;
`endif

  always_ff @(posedge update_clk or posedge reset_clk) begin
    if (reset_clk) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge update_clk or posedge reset_clk) begin
    if (reset_clk) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      adj         <= WORD_SIZE'(ADJ_SEQ);
      ip_step     <= 1'b0;
    end else begin
      mem_req     <= req_d;
      mem_addr    <= addr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      adj         <= adj_d;
      ip_step     <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = mem_addr;
    req_d   = mem_req;
    instr_d = instr;
    valid_d = instr_valid;
    adj_d   = adj;
    step_d  = 1'b0;
    unique case (state_q)
      IDLE, SETTLE: begin
        state_d = IDLE;
        // a latched fault parks the unit until reset
        if (!halt && !fault) begin
          addr_d  = ip;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          instr_d = mem_data;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (expire) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          step_d  = 1'b1;
          adj_d   = branch_taken ? branch_offset :
                                   WORD_SIZE'(ADJ_SEQ);
          state_d = STEP;
        end
      end
      STEP: begin
        state_d = SETTLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
